// File: rtl/miner_controller.sv
// Nonce-search controller: loads a block header, then sweeps nonces through the hash core
// until a hit is found or the nonce space runs out.
module miner_controller #(
  parameter int unsigned NONCE_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_found_i,
  input  logic               midstate_shifts_done_i,
  input  logic               remaining_shifts_done_i,
  input  logic               hash_done_i,
  input  logic               hash_below_target_i,
  input  logic               result_ack_i,
  output logic [2:0]         controller_state_o,
  output logic               shift_en_o,
  output logic               hash_start_o,
  output logic [NONCE_W-1:0] nonce_o,
  output logic               nonce_found_o,
  output logic               exhausted_o
);

  // The encoding is visible on controller_state_o and drives the external shift timer.
  typedef enum logic [2:0] {
    StIdle      = 3'b000,
    StLoadMid   = 3'b001,
    StLoadRem   = 3'b010,
    StHashStart = 3'b011,
    StHashWait  = 3'b100,
    StCheck     = 3'b101,
    StFound     = 3'b110,
    StExhausted = 3'b111
  } state_e;

  localparam logic [NONCE_W-1:0] NonceOne = {{(NONCE_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic               hit_q, hit_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      nonce_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nonce_q <= nonce_d;
      hit_q   <= hit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    nonce_d = nonce_q;
    hit_d   = hit_q;
    unique case (state_q)
      StIdle: begin
        if (start_found_i) begin
          state_d = StLoadMid;
          nonce_d = '0;
        end
      end
      StLoadMid: begin
        // A new start marker restarts the load and wins over the shift timer.
        if (start_found_i) begin
          state_d = StLoadMid;
          nonce_d = '0;
        end else if (midstate_shifts_done_i) begin
          state_d = StLoadRem;
        end
      end
      StLoadRem: begin
        if (start_found_i) begin
          state_d = StLoadMid;
          nonce_d = '0;
        end else if (remaining_shifts_done_i) begin
          state_d = StHashStart;
        end
      end
      StHashStart: state_d = StHashWait;
      StHashWait: begin
        if (hash_done_i) begin
          state_d = StCheck;
          hit_d   = hash_below_target_i;
        end
      end
      StCheck: begin
        // Stop on the last nonce rather than wrapping back to zero.
        if (hit_q) begin
          state_d = StFound;
        end else if (&nonce_q) begin
          state_d = StExhausted;
        end else begin
          state_d = StHashStart;
          nonce_d = nonce_q + NonceOne;
        end
      end
      StFound, StExhausted: begin
        if (result_ack_i) state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    controller_state_o = state_q;
    shift_en_o         = (state_q == StLoadMid) || (state_q == StLoadRem);
    hash_start_o       = (state_q == StHashStart);
    nonce_o            = nonce_q;
    nonce_found_o      = (state_q == StFound);
    exhausted_o        = (state_q == StExhausted);
  end

endmodule

// File: tb/tb_miner_controller.sv
// Self-checking bench for miner_controller: vector table, directed corner sequences and
// randomized stimulus against a behavioural model.
module tb_miner_controller;

  localparam int NW = 4;
  localparam int NMAX = (1 << NW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_found, mid_done, rem_done, hash_done, below, ack;
  logic [2:0]    state_o;
  logic          shift_en_o, hash_start_o, found_o, exh_o;
  logic [NW-1:0] nonce_o;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Behavioural model: spec state codes, nonce as plain integer.
  int m_st, m_nonce;
  bit m_hit;

  miner_controller #(.NONCE_W(NW)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .start_found_i           (start_found),
    .midstate_shifts_done_i  (mid_done),
    .remaining_shifts_done_i (rem_done),
    .hash_done_i             (hash_done),
    .hash_below_target_i     (below),
    .result_ack_i            (ack),
    .controller_state_o      (state_o),
    .shift_en_o              (shift_en_o),
    .hash_start_o            (hash_start_o),
    .nonce_o                 (nonce_o),
    .nonce_found_o           (found_o),
    .exhausted_o             (exh_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_nonce = 0; m_hit = 0;
  endtask

  task automatic model_step(input bit sf, md, rd, hd, hb, ak);
    case (m_st)
      0: if (sf) begin m_st = 1; m_nonce = 0; end
      1: if (sf) begin m_st = 1; m_nonce = 0; end else if (md) m_st = 2;
      2: if (sf) begin m_st = 1; m_nonce = 0; end else if (rd) m_st = 3;
      3: m_st = 4;
      4: if (hd) begin m_st = 5; m_hit = hb; end
      5: if (m_hit) m_st = 6;
         else if (m_nonce == NMAX) m_st = 7;
         else begin m_st = 3; m_nonce = m_nonce + 1; end
      default: if (ak) m_st = 0;
    endcase
  endtask

  task automatic check_model(input string tag);
    int exp_flags, act_flags;
    exp_flags = {28'd0, (m_st == 1 || m_st == 2), (m_st == 3), (m_st == 6), (m_st == 7)};
    act_flags = {28'd0, shift_en_o, hash_start_o, found_o, exh_o};
    check({tag, "_state"}, int'(state_o), m_st);
    check({tag, "_nonce"}, int'(nonce_o), m_nonce);
    check({tag, "_flags"}, act_flags, exp_flags);
  endtask

  // One clock: drive inputs, step the model at the edge, sample 1 time unit later.
  task automatic cyc(input string tag, input bit r, sf, md, rd, hd, hb, ak);
    rst = r; start_found = sf; mid_done = md; rem_done = rd;
    hash_done = hd; below = hb; ack = ak;
    if (r) model_reset();
    @(posedge clk);
    if (!r) model_step(sf, md, rd, hd, hb, ak);
    #1;
    if (hash_start_o) pulses++;
    check_model(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_model("rst_async");
    cyc("rst_hold", 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load_hdr(input string tag);
    cyc(tag, 0, 1, 0, 0, 0, 0, 0);
    cyc(tag, 0, 0, 1, 0, 0, 0, 0);
    cyc(tag, 0, 0, 0, 1, 0, 0, 0);
  endtask

  // Answer every HASH_WAIT with hash_done; hit when the nonce equals hit_at (-1: never).
  task automatic search(input string tag, input int hit_at);
    int budget = 300;
    while (!(m_st == 6 || m_st == 7) && budget > 0) begin
      cyc(tag, 0, 0, 0, 0, m_st == 4, (m_st == 4) && (m_nonce == hit_at), 0);
      budget--;
    end
    check({tag, "_budget"}, int'(budget > 0), 1);
  endtask

  typedef struct packed {
    logic sf, md, rd, hd, hb, ak;
    logic [2:0] st;
    logic [3:0] n;
  } vec_t;

  vec_t tbl[17];

  initial begin
    rst = 1'b1; start_found = 0; mid_done = 0; rem_done = 0;
    hash_done = 0; below = 0; ack = 0;
    model_reset();

    // Vector table: inputs applied for one edge, expected state/nonce after it.
    tbl[0]  = '{0, 0, 0, 1, 1, 0, 3'd0, 4'd0};  // hash_done ignored in IDLE
    tbl[1]  = '{0, 0, 0, 0, 0, 1, 3'd0, 4'd0};  // ack ignored in IDLE
    tbl[2]  = '{1, 0, 0, 0, 0, 0, 3'd1, 4'd0};
    tbl[3]  = '{0, 0, 1, 0, 0, 0, 3'd1, 4'd0};  // rem_done ignored in LOAD_MID
    tbl[4]  = '{0, 1, 0, 0, 0, 0, 3'd2, 4'd0};
    tbl[5]  = '{1, 0, 1, 0, 0, 0, 3'd1, 4'd0};  // restart beats rem_done
    tbl[6]  = '{0, 1, 0, 0, 0, 0, 3'd2, 4'd0};
    tbl[7]  = '{0, 0, 1, 0, 0, 0, 3'd3, 4'd0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 3'd4, 4'd0};
    tbl[9]  = '{1, 0, 0, 0, 0, 1, 3'd4, 4'd0};  // start/ack ignored in HASH_WAIT
    tbl[10] = '{0, 0, 0, 1, 0, 0, 3'd5, 4'd0};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 3'd3, 4'd1};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 3'd4, 4'd1};
    tbl[13] = '{0, 0, 0, 1, 1, 0, 3'd5, 4'd1};
    tbl[14] = '{1, 0, 0, 0, 0, 0, 3'd6, 4'd1};
    tbl[15] = '{1, 0, 0, 1, 0, 0, 3'd6, 4'd1};  // start/hash_done ignored in FOUND
    tbl[16] = '{0, 0, 0, 0, 0, 1, 3'd0, 4'd1};

    do_reset();
    for (int i = 0; i < 17; i++) begin
      cyc("tbl", 0, tbl[i].sf, tbl[i].md, tbl[i].rd, tbl[i].hd, tbl[i].hb, tbl[i].ak);
      check($sformatf("tbl%0d_state", i), int'(state_o), int'(tbl[i].st));
      check($sformatf("tbl%0d_nonce", i), int'(nonce_o), int'(tbl[i].n));
    end

    // Nominal load with real timer spacing, hit on nonce 0.
    do_reset();
    cyc("nom", 0, 1, 0, 0, 0, 0, 0);
    idle("nom", 7);
    cyc("nom", 0, 0, 1, 0, 0, 0, 0);
    idle("nom", 15);
    cyc("nom", 0, 0, 0, 1, 0, 0, 0);
    check("nom_hs_state", int'(state_o), 3);
    idle("nom", 1);
    cyc("nom", 0, 0, 0, 0, 1, 1, 0);
    idle("nom", 1);
    check("nom_found", int'(found_o), 1);
    check("nom_nonce", int'(nonce_o), 0);

    // Multi-nonce search: misses 0..4, hit on 5.
    do_reset();
    load_hdr("multi");
    pulses = 1;
    search("multi", 5);
    check("multi_pulses", pulses, 6);
    check("multi_found", int'(found_o), 1);
    check("multi_nonce", int'(nonce_o), 5);
    cyc("multi_ack", 0, 0, 0, 0, 0, 0, 1);
    check("multi_idle", int'(state_o), 0);

    // Exhaustion: every nonce misses; must stop at all-ones.
    do_reset();
    load_hdr("exh");
    pulses = 1;
    search("exh", -1);
    check("exh_pulses", pulses, 16);
    check("exh_flag", int'(exh_o), 1);
    check("exh_nonce", int'(nonce_o), NMAX);
    idle("exh_hold", 3);
    check("exh_nowrap", int'(nonce_o), NMAX);
    cyc("exh_ack", 0, 0, 0, 0, 0, 0, 1);

    // Async reset mid-hash with a nonzero nonce.
    do_reset();
    load_hdr("arst");
    idle("arst", 1);
    cyc("arst", 0, 0, 0, 0, 1, 0, 0);
    idle("arst", 2);
    check("arst_wait", int'(state_o), 4);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("arst_state", int'(state_o), 0);
    check("arst_nonce", int'(nonce_o), 0);
    #1 rst = 1'b0;
    cyc("arst_hd", 0, 0, 0, 0, 1, 1, 0);
    check("arst_ignored", int'(state_o), 0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cyc("rnd", ($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/miner_controller.md
MINER_CONTROLLER -- requirements
Module: miner_controller

Interface
REQ-001 Parameter NONCE_W, default 32, nonce counter width in bits.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-high.
REQ-004 start_found  input  1  start-of-block marker from the serial front end; begins or restarts a header load.
REQ-005 midstate_shifts_done  input  1  shift timer at count 7, i.e. 8 midstate shifts taken.
REQ-006 remaining_shifts_done  input  1  shift timer at count 23, i.e. 24 total shifts taken.
REQ-007 hash_done  input  1  hash core finished the current nonce; single-cycle pulse.
REQ-008 hash_below_target  input  1  hash result meets target; valid only in the hash_done cycle.
REQ-009 result_ack  input  1  host has consumed a found or exhausted result.
REQ-010 controller_state  output  3  encoded FSM state; drives the shift timer.
REQ-011 shift_en  output  1  header shift register enable.
REQ-012 hash_start  output  1  single-cycle launch pulse to the hash core.
REQ-013 nonce  output  NONCE_W  current nonce under test; holds the winning nonce in FOUND.
REQ-014 nonce_found  output  1  a winning nonce is presented.
REQ-015 exhausted  output  1  full nonce space searched without a hit.

Function
REQ-016 FSM encoding SHALL be fixed: IDLE=000, LOAD_MID=001, LOAD_REM=010, HASH_START=011, HASH_WAIT=100, CHECK=101, FOUND=110, EXHAUSTED=111.
REQ-017 controller_state SHALL be the state register output directly, with no added latency.
REQ-018 IDLE: start_found -> LOAD_MID in the next cycle, nonce cleared to 0 on the same edge.
REQ-019 LOAD_MID: midstate_shifts_done -> LOAD_REM.
REQ-020 LOAD_REM: remaining_shifts_done -> HASH_START.
REQ-021 start_found in LOAD_MID or LOAD_REM -> LOAD_MID with nonce cleared; this takes priority over either shifts_done input in the same cycle.
REQ-022 HASH_START: lasts exactly one cycle, hash_start=1, then HASH_WAIT unconditionally.
REQ-023 HASH_WAIT: hash_done -> CHECK; hash_below_target latched into an internal hit flag on the same edge.
REQ-024 CHECK: hit=1 -> FOUND, nonce unchanged.
REQ-025 CHECK: hit=0 and nonce all-ones -> EXHAUSTED, nonce unchanged (no wrap to 0).
REQ-026 CHECK: hit=0 and nonce not all-ones -> HASH_START with nonce+1 (modulo 2^NONCE_W, never reached at wrap).
REQ-027 FOUND: nonce_found=1, nonce held; result_ack -> IDLE.
REQ-028 EXHAUSTED: exhausted=1; result_ack -> IDLE.
REQ-029 start_found SHALL be ignored in HASH_START, HASH_WAIT, CHECK, FOUND and EXHAUSTED.
REQ-030 hash_done outside HASH_WAIT SHALL be ignored.
REQ-031 result_ack outside FOUND and EXHAUSTED SHALL be ignored.
REQ-032 shift_en=1 iff state is LOAD_MID or LOAD_REM.
REQ-033 hash_start=1 iff state is HASH_START.
REQ-034 nonce_found=1 iff state is FOUND; exhausted=1 iff state is EXHAUSTED.
REQ-035 All outputs SHALL be decoded from registered state/nonce only, with no combinational path from any input.
REQ-036 Minimum per-nonce loop SHALL be 3 cycles when hash_done arrives on the first HASH_WAIT cycle: HASH_START -> HASH_WAIT -> CHECK.

Reset
REQ-037 rst=1 SHALL immediately force state=IDLE, nonce=0 and hit=0, in any state including mid-load and mid-hash.
REQ-038 During reset: controller_state=000 and shift_en, hash_start, nonce_found, exhausted all 0.
REQ-039 First transition after rst deasserts SHALL require a fresh start_found.

Verification
REQ-040 Nominal load and hit:
- Stimulus: start_found; midstate_shifts_done 8 cycles later; remaining_shifts_done 16 cycles after that; hash_done with below_target=1 on nonce 0.
- Response: states 001 -> 010 -> 011 -> 100 -> 101 -> 110; nonce_found=1; nonce=0.
REQ-041 Multi-nonce search:
- Stimulus: misses on nonces 0..4, hit on 5.
- Response: exactly 6 hash_start pulses; FOUND with nonce=5; result_ack -> 000 next cycle.
REQ-042 Exhaustion, with NONCE_W=4:
- Stimulus: all 16 nonces miss.
- Response: 16 hash_start pulses; EXHAUSTED with nonce=4'hF; no wrap to 0.
REQ-043 Restart during load:
- Stimulus: start_found in LOAD_REM on the same cycle as remaining_shifts_done.
- Response: next state 001; nonce=0; no hash_start pulse.
REQ-044 Async reset mid-hash:
- Stimulus: rst pulsed in HASH_WAIT between clock edges.
- Response: state=000 and nonce=0 before the next edge; later hash_done ignored.
REQ-045 Ignored inputs:
- Stimulus: start_found and result_ack in HASH_WAIT; hash_done in IDLE.
- Response: no state change in either case.
